// File: rtl/truth_table_pkg.sv
// Shared types and constants for the truth-table sequencer and its result RAM.
package truth_table_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam int NUM_INPUTS = 4;
  localparam int NUM_FUNCS  = 10;
  localparam int NUM_ROWS   = 2**NUM_INPUTS;
  localparam int SIG_WIDTH  = 16;
  localparam int CNT_WIDTH  = 8;

  typedef logic [NUM_INPUTS-1:0] row_t;
  typedef logic [NUM_FUNCS-1:0]  result_t;

endpackage

// File: rtl/tt_result_ram.sv
// Per-row result store: one write port, one registered read port (read-before-write).
module tt_result_ram #(
  parameter int AW = 4,
  parameter int DW = 10
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  input  logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_data
);

  logic [DW-1:0] mem [2**AW];

  // Contents deliberately survive reset so results can be read after an abort.
  always_ff @(posedge clk) begin
    if (we) mem[wr_addr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (rst) rd_data <= '0;
    else     rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/truth_table_sequencer.sv
// Sweeps every input combination, settles, and captures the function outputs per row.
// Optional MISR signature enabled by TRUTH_TABLE_SEQUENCER_SIGNATURE_EN.
module truth_table_sequencer
  import truth_table_pkg::*;
#(
  parameter int SETTLE_CYCLES = 60,
  parameter int NUM_INPUTS    = truth_table_pkg::NUM_INPUTS,
  parameter int NUM_FUNCS     = truth_table_pkg::NUM_FUNCS
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 stop,
  output logic [NUM_INPUTS-1:0] vec_out,
  input  logic [NUM_FUNCS-1:0] f_in,
  output logic                 sample_stb,
  output logic                 busy,
  output logic                 done,
  input  logic [NUM_INPUTS-1:0] rd_addr,
  output logic [NUM_FUNCS-1:0] rd_data,
  output logic [SIG_WIDTH-1:0] signature
);

  state_t               state, nxt;
  logic [CNT_WIDTH-1:0] cnt;
  logic                 last_row, settled, accept;

  assign last_row   = (vec_out == '1);
  assign settled    = (cnt == CNT_WIDTH'(SETTLE_CYCLES-1));
  assign accept     = (state == IDLE) && start;
  assign sample_stb = (state == SAMPLE);
  assign busy       = (state == SETTLE) || (state == SAMPLE);
  assign done       = (state == DONE);

  always_comb begin
    nxt = state;
    case (state)
      IDLE:    if (start) nxt = SETTLE;
      SETTLE:  if (stop) nxt = IDLE;
               else if (settled) nxt = SAMPLE;
      SAMPLE:  if (stop) nxt = IDLE;
               else if (last_row) nxt = DONE;
               else nxt = SETTLE;
      DONE:    nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      vec_out <= '0;
    end else begin
      state <= nxt;
      case (state)
        IDLE: if (start) begin
          vec_out <= '0;
          cnt     <= '0;
        end
        SETTLE: cnt <= cnt + 1'b1;
        // Last-row guard keeps vec_out at all ones instead of wrapping.
        SAMPLE: if (!stop && !last_row) begin
          vec_out <= vec_out + 1'b1;
          cnt     <= '0;
        end
        default: ;
      endcase
    end
  end

  tt_result_ram #(.AW(NUM_INPUTS), .DW(NUM_FUNCS)) u_ram (
    .clk     (clk),
    .rst     (rst),
    .we      (sample_stb),
    .wr_addr (vec_out),
    .wr_data (f_in),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

`ifdef TRUTH_TABLE_SEQUENCER_SIGNATURE_EN
  logic [SIG_WIDTH-1:0] sig;

  always_ff @(posedge clk) begin
    if (rst)             sig <= '0;
    else if (accept)     sig <= '0;
    else if (sample_stb) sig <= {sig[SIG_WIDTH-2:0], sig[SIG_WIDTH-1]} ^ SIG_WIDTH'(f_in);
  end

  assign signature = sig;
`else
  logic unused_accept;
  assign unused_accept = accept;
  assign signature     = '0;
`endif

endmodule

// File: tb/tb_truth_table_sequencer.sv
// Randomized self-checking bench for truth_table_sequencer against a cycle-offset reference model.
module tb_truth_table_sequencer;

  localparam int S  = 2;
  localparam int P  = S + 1;
  localparam int NI = 4;
  localparam int NF = 10;
  localparam int R  = 2**NI;

  logic          clk = 1'b0;
  logic          rst, start, stop;
  logic [NI-1:0] vec_out, rd_addr;
  logic [NF-1:0] f_in, rd_data;
  logic          sample_stb, busy, done;
  logic [15:0]   signature;

  truth_table_sequencer #(.SETTLE_CYCLES(S), .NUM_INPUTS(NI), .NUM_FUNCS(NF)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .stop       (stop),
    .vec_out    (vec_out),
    .f_in       (f_in),
    .sample_stb (sample_stb),
    .busy       (busy),
    .done       (done),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .signature  (signature)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;
  int cyc    = 0;

  // Model: a sweep is described by its start cycle; everything else is arithmetic on the offset.
  bit          m_act = 0;
  int          m_t0  = 0;
  int          m_vec = 0;
  logic [NF-1:0] m_mem [R];
  bit          m_vld [R];
  logic [NF-1:0] m_rd = '0;
  bit          m_rd_vld = 1;
  logic [15:0] m_sig = '0;
  bit          e_busy, e_smp, e_done;
  int          fmode = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs === exp) passed++;
    else $display("FAIL %s cyc=%0d got %h exp %h", tag, cyc, obs, exp);
  endtask

  task automatic tick();
    int r;
    r      = cyc - m_t0;
    e_busy = m_act && r >= 1 && r <= R*P;
    e_smp  = e_busy && (r % P == 0);
    e_done = m_act && r == R*P + 1;
    if (e_busy) m_vec = (r - 1) / P;
    case (fmode)
      1:       f_in = NF'(m_vec);
      2:       f_in = '1;
      default: f_in = NF'($urandom);
    endcase
    @(negedge clk);
    chk("vec_out", 32'(vec_out), 32'(m_vec));
    chk("busy", 32'(busy), 32'(e_busy));
    chk("sample_stb", 32'(sample_stb), 32'(e_smp));
    chk("done", 32'(done), 32'(e_done));
`ifdef TRUTH_TABLE_SEQUENCER_SIGNATURE_EN
    chk("signature", 32'(signature), 32'(m_sig));
`else
    chk("signature", 32'(signature), 32'd0);
`endif
    if (m_rd_vld) chk("rd_data", 32'(rd_data), 32'(m_rd));
    if (rst) begin
      m_act = 0; m_vec = 0; m_rd = '0; m_rd_vld = 1; m_sig = '0;
    end else begin
      m_rd     = m_mem[rd_addr];
      m_rd_vld = m_vld[rd_addr];
      if (e_smp) begin
        m_mem[m_vec] = f_in;
        m_vld[m_vec] = 1;
        m_sig = {m_sig[14:0], m_sig[15]} ^ {6'b0, f_in};
      end
      if ((e_busy && stop) || e_done) m_act = 0;
      else if (!m_act && start) begin
        m_act = 1; m_t0 = cyc; m_sig = '0;
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic sweep(input int stop_row, input int rst_row, input bit dbl_start,
                       input int mode, input int stop_pct);
    fmode   = mode;
    start   = 1;
    stop    = 1'($urandom_range(1));
    rst     = 0;
    rd_addr = NI'($urandom);
    tick();
    start = 0;
    for (int k = 1; k <= R*P + 1; k++) begin
      stop    = (stop_row >= 0 && k == stop_row*P + 1) || ($urandom_range(99) < stop_pct);
      rst     = (rst_row >= 0 && k == rst_row*P + 2);
      start   = dbl_start && (k == 5 || k == R*P + 1);
      rd_addr = NI'($urandom);
      tick();
      if (!m_act) break;
    end
    start = 0; stop = 0; rst = 0;
    for (int a = 0; a < R + 2; a++) begin
      rd_addr = NI'(a % R);
      tick();
    end
  endtask

  initial begin
    for (int i = 0; i < R; i++) m_vld[i] = 0;
    rst = 1; start = 0; stop = 0; rd_addr = '0; f_in = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 0;
    repeat (3) tick();
    sweep(-1, -1, 0, 1, 0);
    sweep(-1, -1, 1, 0, 0);
    sweep(7, -1, 0, 0, 0);
    sweep(-1, 9, 0, 0, 0);
    sweep(-1, -1, 0, 2, 0);
    repeat (4) sweep(-1, -1, 1'($urandom_range(1)), 0, 2);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/truth_table_sequencer.md
Name: truth_table_sequencer

Overview:
Upstream stimulus stage for the 4-input breadboard function block.
- Sweeps all 2^NUM_INPUTS input combinations on vec_out[3:0], which drive w,x,y,z with vec_out[3]=w.
- Holds each combination for a settle interval, then captures the block's f0..f9 return bus (f_in) into a per-row result memory.
- Hardware replacement for the hand-written sweep loop; a downstream checker or display reads results by address after done.

Parameters:
- SETTLE_CYCLES, 60, clock cycles each vector is held before sampling; legal 1..255.
- NUM_INPUTS, 4, input vector width; number of rows = 2^NUM_INPUTS.
- NUM_FUNCS, 10, width of f_in, one bit per function output f0..f9.

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst  in  1  synchronous active-high reset.
- start  in  1  one-cycle pulse; begins a sweep when idle.
- stop  in  1  abort request; ends a sweep early.
- vec_out  out  NUM_INPUTS  current input combination to the function block.
- f_in  in  NUM_FUNCS  function outputs returned from the block; f_in[0]=f0.
- sample_stb  out  1  high for the one cycle in which f_in is captured.
- busy  out  1  high while a sweep is in progress.
- done  out  1  one-cycle pulse when a full sweep completes.
- rd_addr  in  NUM_INPUTS  result memory read address (row index).
- rd_data  out  NUM_FUNCS  result row; registered, 1-cycle latency.
- signature  out  16  MISR signature of captured rows (optional feature).

Behaviour:
- Reset: vec_out=0, sample_stb=0, busy=0, done=0, rd_data=0, signature=0, state=IDLE, settle counter=0.
  - Result memory is not cleared by reset.
  - rst overrides everything, including mid-sweep.
- States:
  - IDLE: start=1 -> SETTLE with vec_out=0 and cnt=0.
  - SETTLE: cnt increments each cycle. When cnt==SETTLE_CYCLES-1 -> SAMPLE.
  - SAMPLE: 1 cycle. sample_stb=1; mem[vec_out] <= f_in.
    - If vec_out==2^NUM_INPUTS-1 -> DONE.
    - Otherwise vec_out <= vec_out+1, cnt <= 0 -> SETTLE.
  - DONE: done=1 for 1 cycle -> IDLE.
- vec_out changes only on SETTLE entry. It holds its last value (all ones) after a full sweep.
- Per-row period: SETTLE_CYCLES+1 cycles.
- Full sweep: 2^NUM_INPUTS*(SETTLE_CYCLES+1) busy cycles, then the done cycle.
- busy=1 in SETTLE and SAMPLE only; 0 in IDLE and DONE.
- start while busy or in DONE is ignored; it is not queued.
- stop, in SETTLE or SAMPLE:
  - Next state is IDLE; done is not pulsed.
  - If asserted in SAMPLE, the current row is still written.
  - vec_out holds its value. Previously written rows are retained.
- stop and start together in IDLE: start wins.
- Counter wraps never occur: vec_out increment is guarded by the last-row compare. cnt is log2(256)=8 bits wide.
- rd_data <= mem[rd_addr] every cycle, independent of state.
  - If a read and a SAMPLE write hit the same address in the same cycle, rd_data returns the old value (read-before-write).

Optional Feature:
- Macro: TRUTH_TABLE_SEQUENCER_SIGNATURE_EN.
- With it defined:
  - 16-bit MISR; cleared to 0 on accepted start.
  - On each sample_stb: sig <= {sig[14:0],sig[15]} ^ zero-extended f_in.
  - signature output reflects sig and holds after DONE or stop until the next start or rst.
- Without it: signature is tied to 0 and no MISR logic exists.

Decomposition:
- Shared package truth_table_pkg holds:
  - state enum (IDLE, SETTLE, SAMPLE, DONE);
  - constants NUM_ROWS = 2**NUM_INPUTS and SIG_WIDTH = 16;
  - row/result typedefs.
- One natural sub-module: tt_result_ram (NUM_ROWS x NUM_FUNCS, 1 write port, 1 registered read port).
- FSM, settle counter and MISR stay in the top module.

Test Plan:
- SETTLE_CYCLES=2, f_in = {6'b0, vec_out} loop-back, pulse start at cycle 0 -> busy for 48 cycles; sample_stb at cycles 3,6,...,48; done pulse at cycle 49; rd_addr=5 -> rd_data=10'h005 one cycle later.
- Mid-sweep stop during SETTLE of row 7 -> IDLE next cycle, done stays 0, vec_out=7, rows 0..6 hold captured values, row 7 is unchanged.
- start pulsed again while busy -> ignored; sweep length and done timing identical to the first test.
- rst asserted at row 9 -> all outputs return to reset values next cycle; a new start sweeps from vec_out=0.
- With TRUTH_TABLE_SEQUENCER_SIGNATURE_EN and constant f_in=10'h3FF -> signature after 16 samples matches the model value computed from the MISR rule; it is cleared on the next start.
- Without the macro, same stimulus -> signature==0 throughout.
